btn_conditioner: RTL
====================

# btn_conditioner

Conditions the three raw stopwatch push-buttons (start, stop, inc) before they reach the stopwatch state machine. Runs on the 1 kHz clock from the clock divider (one cycle = 1 ms). Per channel it synchronises, debounces and converts each press into a single-cycle pulse. The inc channel optionally auto-repeats while held.

## Interface
Parameters:
- DEBOUNCE_MS, 20: consecutive cycles a synchronised input must differ from the debounced level before the level flips (1..255).
- REPEAT_DELAY, 500: cycles from the first inc pulse to the first repeat pulse (1..4095).
- REPEAT_PERIOD, 100: cycles between successive repeat pulses (1..4095).

Ports:
- clk  in  1  1 kHz system tick from the clock divider.
- rst  in  1  asynchronous, active-low reset.
- btn_start  in  1  raw start button, asynchronous, active-high.
- btn_stop  in  1  raw stop button, asynchronous, active-high.
- btn_inc  in  1  raw inc button, asynchronous, active-high.
- start  out  1  one-cycle press pulse to the state machine.
- stop  out  1  one-cycle press pulse to the state machine.
- inc  out  1  one-cycle press/repeat pulse to the state machine.
- btn_level  out  3  debounced levels {inc, stop, start}.

## Operation
- Reset: all outputs, synchroniser flops, debounced levels, counters and the repeat FSM go to 0/IDLE immediately on rst low. The block leaves reset on the first clk edge with rst high.
- Synchroniser: each raw input passes through a 2-flop synchroniser. Only the second flop is used downstream.
- Debounce, per channel:
  - 8-bit counter.
  - If the sync value equals the debounced level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_MS, the level takes the sync value and the counter clears.
  - Any single matching cycle restarts the count.
- Press pulse: registered. Asserted for exactly one cycle after a debounced 0->1 transition. A 1->0 transition produces nothing.
- start/stop conflict: if start and stop press pulses would assert in the same cycle, stop is asserted and start is dropped (not deferred).
- Auto-repeat FSM (inc only), 12-bit counter:
  - IDLE: on an inc press pulse, go to HOLD and clear the counter.
  - HOLD: increment while the debounced inc is high. At REPEAT_DELAY, pulse inc, clear the counter and go to REPEAT.
  - REPEAT: increment. At REPEAT_PERIOD, pulse inc and clear the counter.
  - In HOLD or REPEAT, a debounced inc low returns the FSM to IDLE in the same cycle and suppresses any pulse due that cycle.
- inc output is the OR of the press pulse and the repeat pulse. The two never coincide by construction.

## Timing
- Press latency: the raw input is first sampled high at edge 0 and held. The debounced level rises at edge DEBOUNCE_MS+1. The press pulse is high for the cycle following edge DEBOUNCE_MS+2. With defaults, the pulse is at edge 22.
- Release latency is symmetric: the debounced level falls at edge DEBOUNCE_MS+1 after the first low sample.
- Repeat pulses: first at press pulse + REPEAT_DELAY, then every REPEAT_PERIOD cycles. With defaults: 522, 622, 722, …
- All outputs are registered. No combinational path exists from btn_* to any output.
- Reset mid-press: outputs drop asynchronously. After reset, a still-held button is treated as a new press and pulses after the full debounce latency.
- Minimum press-to-press spacing for two pulses: 2×(DEBOUNCE_MS+1) cycles.

## Configuration
- AUTO_REPEAT_EN defined: auto-repeat FSM and repeat counter are compiled in, as described above.
- AUTO_REPEAT_EN undefined: FSM and counter are omitted. inc behaves exactly like start/stop (single press pulse). REPEAT_DELAY and REPEAT_PERIOD are unused.

## Test plan
- Clean press: btn_start high from edge 0 for 100 cycles, then low -> start high for exactly one cycle after edge 22. btn_level[0] is high from edge 21 to edge 121 (falls at 100 + DEBOUNCE_MS + 1).
- Bounce rejection: btn_stop pulses high 5 cycles, low 3, high 5, then low -> stop never asserts and btn_level[1] stays 0.
- Simultaneous press: btn_start and btn_stop rise on the same edge and are held -> stop pulses at edge 22 and start never asserts.
- Auto-repeat (AUTO_REPEAT_EN): btn_inc held from edge 0 to edge 950 -> inc pulses at edges 22, 522, 622, 722, 822, 922 (6 pulses), with no pulse at or after 1022. Without the macro, the same stimulus gives one pulse at edge 22.
- Reset mid-hold: btn_inc held, rst low at edge 300 for 3 cycles -> all outputs 0 immediately. After release, inc pulses again 22 cycles later, then follows the repeat schedule.
- Reset values: rst low with all buttons high -> start/stop/inc = 0 and btn_level = 3'b000 throughout reset.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and one-shot the start/stop/inc buttons.
// Define AUTO_REPEAT_EN to compile in the inc auto-repeat FSM.
module btn_conditioner #(
  parameter int DEBOUNCE_MS   = 20,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_inc,
  output logic       start,
  output logic       stop,
  output logic       inc,
  output logic [2:0] btn_level
);
  logic [2:0] raw, s1, s2, lvl, prv, rise;
  logic [7:0] cnt [3];

  if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 255 || REPEAT_DELAY < 1 || REPEAT_DELAY > 4095 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > 4095) begin : g_bad_param
    $error("btn_conditioner: parameter out of range");
  end

  assign raw = {btn_inc, btn_stop, btn_start};
  assign rise = lvl & ~prv;
  assign btn_level = lvl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      lvl <= '0;
      prv <= '0;
      start <= 1'b0;
      stop <= 1'b0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      prv <= lvl;
      // stop wins a same-cycle conflict; start is simply dropped
      start <= rise[0] & ~rise[1];
      stop <= rise[1];
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == lvl[i]) cnt[i] <= '0;
        else if (cnt[i] == 8'(DEBOUNCE_MS - 1)) begin
          lvl[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  state_t state;
  logic [11:0] rcnt;

  // entering HOLD on the same edge the press pulse is registered keeps repeats at press + delay
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rcnt <= '0;
      inc <= 1'b0;
    end else begin
      inc <= rise[2];
      case (state)
        IDLE: if (rise[2]) begin
          state <= HOLD;
          rcnt <= '0;
        end
        HOLD: if (!lvl[2]) state <= IDLE;
        else if (rcnt == 12'(REPEAT_DELAY - 1)) begin
          inc <= 1'b1;
          rcnt <= '0;
          state <= REPEAT;
        end else rcnt <= rcnt + 12'd1;
        REPEAT: if (!lvl[2]) state <= IDLE;
        else if (rcnt == 12'(REPEAT_PERIOD - 1)) begin
          inc <= 1'b1;
          rcnt <= '0;
        end else rcnt <= rcnt + 12'd1;
        default: state <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inc <= 1'b0;
    else inc <= rise[2];
  end
`endif
endmodule
